// File: rtl/adc_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_capture_pkg: shared types, defaults and length helper for the    |
// | ADC capture channel.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_capture_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 10;
  localparam int STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // A length of zero or anything beyond the RAM depth means "fill the RAM".
  function automatic logic [31:0] eff_len(input logic [31:0] cfg_len, input int addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    if (cfg_len == 32'd0 || cfg_len > depth) begin
      return depth;
    end
    return cfg_len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_trig_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_trig_edge: rising-edge detect on the external trigger, merged    |
// | with the software trigger pulse.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_trig_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_ext,
  input  logic trig_sw,
  output logic trig_evt
);

  logic trig_ext_d_q;
  logic trig_ext_d_d;

  // Tracked in every state so a level already high at arm time never fires.
  always_comb begin
    trig_ext_d_d = trig_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_ext_d_q <= 1'b0;
    end else begin
      trig_ext_d_q <= trig_ext_d_d;
    end
  end

  assign trig_evt = (trig_ext & ~trig_ext_d_q) | trig_sw;

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_capture_ctrl: arm / trigger / capture sequencer writing a        |
// | programmed number of ADC samples into the capture RAM.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              arm,
  input  logic              abort,
  input  logic              done_clr,
  input  logic              trig_ext,
  input  logic              trig_sw,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt
);

  localparam int LEN_W = ADDR_W + 1;

  state_e            state_q,      state_d;
  logic [LEN_W-1:0]  len_q,        len_d;
  logic [LEN_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic              wr_en_q,      wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;
  logic              trig_evt;
  logic [LEN_W-1:0]  arm_len;

  adc_trig_edge u_trig_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig_ext (trig_ext),
    .trig_sw  (trig_sw),
    .trig_evt (trig_evt)
  );

  assign arm_len = LEN_W'(eff_len(32'(cfg_len), ADDR_W));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d      = ST_ARMED;
            len_d        = arm_len;
            sample_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          if (trig_evt) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (adc_valid) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = sample_cnt_q[ADDR_W-1:0];
            wr_data_d    = adc_data;
            sample_cnt_d = sample_cnt_q + LEN_W'(1);
            if (sample_cnt_q == len_q - LEN_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // A re-arm takes precedence over a simultaneous done_clr.
          if (arm) begin
            state_d      = ST_ARMED;
            len_d        = arm_len;
            sample_cnt_d = '0;
          end else if (done_clr) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      sample_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign sample_cnt  = sample_cnt_q;
  assign armed       = (state_q == ST_ARMED);
  assign busy        = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done        = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_capture_ctrl: scoreboard bench for adc_capture_ctrl with a    |
// | behavioural capture model (ADDR_W=4, DATA_W=12).                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adc_capture_ctrl;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic          arm = 1'b0, abort = 1'b0, done_clr = 1'b0;
  logic          trig_ext = 1'b0, trig_sw = 1'b0, adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          mem_wr_en, armed, busy, done;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [AW:0]   sample_cnt;

  adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .arm(arm), .abort(abort),
    .done_clr(done_clr), .trig_ext(trig_ext), .trig_sw(trig_sw),
    .adc_valid(adc_valid), .adc_data(adc_data), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .armed(armed),
    .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];

  // Reference model: what phase the channel is in, how many samples are stored.
  typedef enum {M_IDLE, M_ARMED, M_CAP, M_DONE} phase_t;
  phase_t     m_phase = M_IDLE;
  int         m_cnt = 0;
  int         m_len = 0;
  bit         m_prev_ext = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        total++; bad++;
        $display("FAIL missed_write: got none expected addr %0d data %0h", sb[0].addr, sb[0].data);
        void'(sb.pop_front());
      end
      if (mem_wr_en) begin
        total++;
        if (sb.size() == 0 || sb[0].at != cyc) begin
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write (cyc %0d)",
                   mem_wr_addr, mem_wr_data, cyc);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (mem_wr_addr != e.addr || mem_wr_data != e.data) begin
            bad++;
            $display("FAIL write_content: got addr %0d data %0h expected addr %0d data %0h",
                     mem_wr_addr, mem_wr_data, e.addr, e.data);
          end
        end
      end
      total++;
      if (armed != (m_phase == M_ARMED) || busy != (m_phase == M_ARMED || m_phase == M_CAP) ||
          done != (m_phase == M_DONE) || int'(sample_cnt) != m_cnt) begin
        bad++;
        $display("FAIL status: got armed=%0b busy=%0b done=%0b cnt=%0d expected phase=%s cnt=%0d",
                 armed, busy, done, sample_cnt, m_phase.name(), m_cnt);
      end
    end
  end

  // One clock of stimulus; the model decides the outcome before the edge.
  task automatic step(input bit a, input bit ab, input bit cl, input bit te,
                      input bit ts, input bit v, input logic [DW-1:0] d);
    phase_t nxt;
    int     ncnt, nlen;
    bit     evt;
    wr_t    e;
    arm = a; abort = ab; done_clr = cl; trig_ext = te; trig_sw = ts;
    adc_valid = v; adc_data = d;
    evt  = (te && !m_prev_ext) || ts;
    nxt  = m_phase; ncnt = m_cnt; nlen = m_len;
    if (ab) begin
      nxt = M_IDLE;
    end else if (a && (m_phase == M_IDLE || m_phase == M_DONE)) begin
      nxt  = M_ARMED;
      nlen = (int'(cfg_len) == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
      ncnt = 0;
    end else if (m_phase == M_DONE && cl) begin
      nxt = M_IDLE;
    end else if (m_phase == M_ARMED && evt) begin
      nxt = M_CAP;
    end else if (m_phase == M_CAP && v) begin
      e.at = cyc + 1; e.addr = AW'(m_cnt); e.data = d;
      sb.push_back(e);
      ncnt = m_cnt + 1;
      if (ncnt == m_len) nxt = M_DONE;
    end
    @(posedge clk); #1;
    m_phase = nxt; m_cnt = ncnt; m_len = nlen; m_prev_ext = te;
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic feed(input int n, input bit toggle);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, toggle ? ((i % 2) == 0) : 1'b1, DW'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, int'(mem_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(mem_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(mem_wr_data), 0);
    chk({tag, "_armed"}, int'(armed), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cnt"}, int'(sample_cnt), 0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_phase = M_IDLE; m_cnt = 0; m_len = 0; m_prev_ext = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycle();

    // Trigger-cycle sample is skipped; four writes of 0x101..0x104.
    cfg_len = 5'd4;
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 1, 12'h100);
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 0, 0, 1, DW'(12'h100 + i));
    chk("basic_done", int'(done), 1);
    chk("basic_cnt", int'(sample_cnt), 4);
    step(0, 0, 1, 0, 0, 0, '0);

    // Level already high at arm time does not trigger.
    cfg_len = 5'd3;
    repeat (3) step(0, 0, 0, 1, 0, 0, '0);
    step(1, 0, 0, 1, 0, 0, '0);
    repeat (20) step(0, 0, 0, 1, 0, 1, DW'($urandom));
    chk("held_trig_armed", int'(armed), 1);
    step(0, 0, 0, 0, 0, 1, DW'($urandom));
    step(0, 0, 0, 1, 0, 1, DW'($urandom));
    feed(5, 1'b0);
    step(0, 0, 1, 0, 0, 0, '0);

    // Zero and oversize lengths both fill the whole RAM.
    for (int k = 0; k < 2; k++) begin
      cfg_len = (k == 0) ? 5'd0 : 5'd17;
      step(1, 0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 1, 0, '0);
      feed(20, 1'b0);
      chk("full_cnt", int'(sample_cnt), 16);
      step(0, 0, 1, 0, 0, 0, '0);
    end

    // Gapped valid stream.
    cfg_len = 5'd8;
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 0, '0);
    feed(20, 1'b1);
    chk("gap_done", int'(done), 1);

    // Abort after three writes with valid high in the abort cycle.
    cfg_len = 5'd10;
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 0, '0);
    feed(3, 1'b0);
    step(0, 1, 0, 0, 0, 1, DW'($urandom));
    chk("abort_cnt", int'(sample_cnt), 3);
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 0, '0);
    feed(4, 1'b0);
    step(0, 1, 0, 0, 0, 0, '0);

    // arm and done_clr together in DONE: arm wins.
    cfg_len = 5'd2;
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 0, '0);
    feed(3, 1'b0);
    step(1, 0, 1, 0, 0, 0, '0);
    chk("rearm_armed", int'(armed), 1);
    chk("rearm_cnt", int'(sample_cnt), 0);

    // Asynchronous reset mid-capture.
    step(0, 0, 0, 0, 1, 1, DW'($urandom));
    feed(1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    adc_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cfg_len = 5'($urandom_range(0, 20));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, DW'($urandom));
    end
    repeat (3) idle_cycle();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
